alu_seq: RTL

Parametrised sequential ALU: the next-generation datapath ALU for the nic8 family. It generalises the 8-bit add/subtract/shift-by-one unit to WIDTH bits. It adds carry-chained ADC/SBC, multi-bit LSR/ASR/ROR/LSL shifts executed one bit per clock, and a start/busy/done handshake. Registered result and flags feed the shared data bus through an active-low output enable, as the current ALU does.

---
 rtl/alu_seq.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : WIDTH-bit sequential ALU with carry-chained add/subtract and
//            bit-serial multi-bit shifts behind a start/busy/done handshake.
//            Optional feature macro: ALU_OVERFLOW_EN (signed overflow flag).
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             resetBar,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] areg,
    input  logic [WIDTH-1:0] breg,
    input  logic [CNT_W-1:0] amount,
    input  logic             assertBarE,
    output logic [WIDTH-1:0] dbus,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             flagCarry,
    output logic             flagShift,
    output logic             flagZero,
    output logic             flagNeg,
    output logic             flagOverflow
);

    localparam logic [1:0] c_SH_LSR = 2'b00;
    localparam logic [1:0] c_SH_ASR = 2'b01;
    localparam logic [1:0] c_SH_ROR = 2'b10;
    localparam logic [1:0] c_SH_LSL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_shift_op;
    logic [WIDTH-1:0]   r_work;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sbit;

    logic [WIDTH-1:0]   r_result;
    logic               r_flag_c;
    logic               r_flag_s;
    logic               r_flag_z;
    logic               r_flag_n;

    logic               w_accept;
    logic               w_is_arith;
    logic               w_amount_zero;
    logic               w_last_step;
    logic [WIDTH-1:0]   w_b_eff;
    logic               w_cin;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_work_nxt;
    logic               w_sbit_nxt;

    assign w_accept      = start && (r_state != S_SHIFT);
    assign w_is_arith    = ~op[2];
    assign w_amount_zero = (amount == '0);
    assign w_last_step   = (r_cnt == CNT_W'(1));

    // op[1] selects subtraction; op[0] chains the stored carry in place of the fixed one.
    assign w_b_eff = op[1] ? ~breg : breg;
    assign w_cin   = op[0] ? r_flag_c : op[1];
    assign w_sum   = {1'b0, areg} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_cin};

    always_comb begin
        w_sbit_nxt = r_work[0];
        w_work_nxt = {1'b0, r_work[WIDTH-1:1]};
        case (r_shift_op)
            c_SH_LSR: ;
            c_SH_ASR: w_work_nxt = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            c_SH_ROR: w_work_nxt = {r_sbit, r_work[WIDTH-1:1]};
            c_SH_LSL: begin
                w_work_nxt = {r_work[WIDTH-2:0], 1'b0};
                w_sbit_nxt = r_work[WIDTH-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetBar) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                done = (r_state == S_DONE);
                if (w_accept) begin
                    w_state_nxt = (w_is_arith || w_amount_zero) ? S_DONE : S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetBar) begin
            r_shift_op <= '0;
            r_work     <= '0;
            r_cnt      <= '0;
            r_sbit     <= 1'b0;
            r_result   <= '0;
            r_flag_c   <= 1'b0;
            r_flag_s   <= 1'b0;
            r_flag_z   <= 1'b0;
            r_flag_n   <= 1'b0;
        end else if (w_accept) begin
            r_shift_op <= op[1:0];
            r_work     <= areg;
            r_cnt      <= amount;
            r_sbit     <= r_flag_s;
            if (w_is_arith) begin
                r_result <= w_sum[WIDTH-1:0];
                r_flag_c <= w_sum[WIDTH];
                r_flag_z <= (w_sum[WIDTH-1:0] == '0);
                r_flag_n <= w_sum[WIDTH-1];
            end else if (w_amount_zero) begin
                r_result <= areg;
                r_flag_z <= (areg == '0);
                r_flag_n <= areg[WIDTH-1];
            end
        end else if (r_state == S_SHIFT) begin
            r_work <= w_work_nxt;
            r_sbit <= w_sbit_nxt;
            r_cnt  <= r_cnt - CNT_W'(1);
            // The final step commits the freshly shifted value, not the old work register.
            if (w_last_step) begin
                r_result <= w_work_nxt;
                r_flag_s <= w_sbit_nxt;
                r_flag_z <= (w_work_nxt == '0);
                r_flag_n <= w_work_nxt[WIDTH-1];
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic r_flag_v;
    logic w_ovf;

    assign w_ovf = (areg[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                   (w_sum[WIDTH-1] != areg[WIDTH-1]);

    always_ff @(posedge clk) begin
        if (!resetBar) begin
            r_flag_v <= 1'b0;
        end else if (w_accept && w_is_arith) begin
            r_flag_v <= w_ovf;
        end
    end

    assign flagOverflow = r_flag_v;
`else
    assign flagOverflow = 1'b0;
`endif

    assign result    = r_result;
    assign flagCarry = r_flag_c;
    assign flagShift = r_flag_s;
    assign flagZero  = r_flag_z;
    assign flagNeg   = r_flag_n;
    assign dbus      = assertBarE ? {WIDTH{1'bz}} : r_result;

endmodule
`default_nettype wire
